// File: rtl/ddc_accum_oct.sv
// ddc_accum_oct: integrate-and-dump decimator for the oct-mode DDC stream.
// Sums N I/Q samples at full precision and emits one word per window via a small FIFO.
//
// Ports:
//   s_axis_aclk, s_axis_aresetn       clock, async active-low reset
//   s_axis_ddc_tdata/tvalid/tready    input samples: Q in [61:32], I in [29:0]
//   s_axis_cfg_tdata/tvalid           decimation ratio N in [DEC_BITS-1:0]
//   resync                            drop the partial window and restart it
//   m_axis_tdata/tuser/tvalid/tready  {Q sum, I sum}, window sequence number
//   overflow                          sticky: a finished window hit a full FIFO
module ddc_accum_oct #(
    parameter int DEC_BITS   = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    input  logic [63:0]              s_axis_ddc_tdata,
    input  logic                     s_axis_ddc_tvalid,
    output logic                     s_axis_ddc_tready,
    input  logic [31:0]              s_axis_cfg_tdata,
    input  logic                     s_axis_cfg_tvalid,
    input  logic                     resync,
    output logic [2*ACC_WIDTH-1:0]   m_axis_tdata,
    output logic [15:0]              m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * ACC_WIDTH + 16;

    typedef enum logic {
        UNCFG = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   accum_en;

    logic [DEC_BITS-1:0]  n_q;
    logic [DEC_BITS-1:0]  n_new;
    logic [DEC_BITS-1:0]  cnt_q;
    logic [DEC_BITS-1:0]  cnt_inc;
    logic [ACC_WIDTH-1:0] acc_i_q;
    logic [ACC_WIDTH-1:0] acc_q_q;
    logic [ACC_WIDTH-1:0] samp_i;
    logic [ACC_WIDTH-1:0] samp_q;
    logic [ACC_WIDTH-1:0] sum_i;
    logic [ACC_WIDTH-1:0] sum_q;
    logic [15:0]          seq_q;
    logic                 ovf_q;

    logic cfg_wr;
    logic take;
    logic last;
    logic pop;
    logic full;
    logic push;
    logic drop;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fcnt;

    logic unused_bits;
    assign unused_bits = ^{s_axis_ddc_tdata[63:62],
                           s_axis_ddc_tdata[31:30],
                           s_axis_cfg_tdata[31:DEC_BITS]};

    assign s_axis_ddc_tready = 1'b1;

    // FSM: state register
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNCFG:   if (cfg_wr) state_d = ACCUM;
            ACCUM:   state_d = ACCUM;
            default: state_d = UNCFG;
        endcase
    end

    // FSM: outputs
    always_comb begin
        accum_en = 1'b0;
        unique case (state_q)
            ACCUM:   accum_en = 1'b1;
            default: accum_en = 1'b0;
        endcase
    end

    assign cfg_wr = s_axis_cfg_tvalid;
    assign n_new  = (s_axis_cfg_tdata[DEC_BITS-1:0] == '0)
                  ? DEC_BITS'(1)
                  : s_axis_cfg_tdata[DEC_BITS-1:0];

    assign samp_i = {{(ACC_WIDTH-30){s_axis_ddc_tdata[29]}},
                     s_axis_ddc_tdata[29:0]};
    assign samp_q = {{(ACC_WIDTH-30){s_axis_ddc_tdata[61]}},
                     s_axis_ddc_tdata[61:32]};
    assign sum_i  = acc_i_q + samp_i;
    assign sum_q  = acc_q_q + samp_q;

    // cfg and resync both pre-empt the sample in their cycle
    assign take    = accum_en && !cfg_wr && !resync && s_axis_ddc_tvalid;
    assign cnt_inc = cnt_q + 1'b1;
    assign last    = take && (cnt_inc == n_q);

    // a pop in the same cycle frees the slot for the dump
    assign pop  = m_axis_tvalid && m_axis_tready;
    assign full = (fcnt == CW'(FIFO_DEPTH));
    assign push = last && (!full || pop);
    assign drop = last && full && !pop;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            n_q     <= DEC_BITS'(1);
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (cfg_wr) begin
            n_q     <= n_new;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accum_en) begin
            if (resync) begin
                cnt_q   <= '0;
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (take) begin
                if (last) begin
                    cnt_q   <= '0;
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    // sequence advances even on a dropped window
                    seq_q   <= seq_q + 16'd1;
                    if (drop) ovf_q <= 1'b1;
                end else begin
                    cnt_q   <= cnt_inc;
                    acc_i_q <= sum_i;
                    acc_q_q <= sum_q;
                end
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {seq_q, sum_q, sum_i};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    assign m_axis_tvalid = (fcnt != '0);
    assign m_axis_tdata  = mem[rd_ptr][2*ACC_WIDTH-1:0];
    assign m_axis_tuser  = mem[rd_ptr][EW-1:2*ACC_WIDTH];
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_ddc_accum_oct.sv
// tb_ddc_accum_oct: directed and random stimulus for ddc_accum_oct.
// A window/queue reference model predicts every output each cycle.
module tb_ddc_accum_oct;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] ddc_tdata = '0;
    logic        ddc_tvalid = 1'b0;
    logic        ddc_tready;
    logic [31:0] cfg_tdata = '0;
    logic        cfg_tvalid = 1'b0;
    logic        resync = 1'b0;
    logic [95:0] m_tdata;
    logic [15:0] m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bit     m_cfg;
    int     m_n;
    int     m_seq;
    bit     m_ovf;
    longint win_i[$];
    longint win_q[$];
    longint fi[$];
    longint fq[$];
    int     fs[$];

    always #5 clk = ~clk;

    ddc_accum_oct dut (
        .s_axis_aclk       (clk),
        .s_axis_aresetn    (rst_n),
        .s_axis_ddc_tdata  (ddc_tdata),
        .s_axis_ddc_tvalid (ddc_tvalid),
        .s_axis_ddc_tready (ddc_tready),
        .s_axis_cfg_tdata  (cfg_tdata),
        .s_axis_cfg_tvalid (cfg_tvalid),
        .resync            (resync),
        .m_axis_tdata      (m_tdata),
        .m_axis_tuser      (m_tuser),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .overflow          (overflow)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cfg = 0;
        m_n   = 1;
        m_seq = 0;
        m_ovf = 0;
        win_i.delete();
        win_q.delete();
        fi.delete();
        fq.delete();
        fs.delete();
    endtask

    task automatic model_update(input bit v, input logic [29:0] si,
                                input logic [29:0] sq, input bit cfg,
                                input logic [31:0] cd, input bit rs,
                                input bit rdy);
        longint a;
        longint b;
        if (fi.size() > 0 && rdy) begin
            void'(fi.pop_front());
            void'(fq.pop_front());
            void'(fs.pop_front());
        end
        if (cfg) begin
            m_cfg = 1;
            m_n   = (cd[15:0] == 16'd0) ? 1 : int'(cd[15:0]);
            m_seq = 0;
            m_ovf = 0;
            win_i.delete();
            win_q.delete();
        end else if (m_cfg && rs) begin
            win_i.delete();
            win_q.delete();
        end else if (m_cfg && v) begin
            win_i.push_back(longint'($signed(si)));
            win_q.push_back(longint'($signed(sq)));
            if (win_i.size() == m_n) begin
                a = 0;
                b = 0;
                foreach (win_i[k]) a += win_i[k];
                foreach (win_q[k]) b += win_q[k];
                if (fi.size() < DEPTH) begin
                    fi.push_back(a);
                    fq.push_back(b);
                    fs.push_back(m_seq);
                end else begin
                    m_ovf = 1;
                end
                m_seq = (m_seq + 1) % 65536;
                win_i.delete();
                win_q.delete();
            end
        end
    endtask

    task automatic check_outputs();
        longint ei;
        longint eq;
        int     es;
        logic [95:0] ed;
        chk("tready", ddc_tready, 1'b1);
        chk("tvalid", m_tvalid, fi.size() > 0);
        if (fi.size() > 0) begin
            ei = fi[0];
            eq = fq[0];
            es = fs[0];
            ed = {eq[47:0], ei[47:0]};
            chk("tdata", m_tdata, ed);
            chk("tuser", m_tuser, es[15:0]);
        end
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit v, input logic [29:0] si,
                        input logic [29:0] sq, input bit cfg,
                        input logic [31:0] cd, input bit rs,
                        input bit rdy);
        ddc_tvalid = v;
        ddc_tdata  = {2'($urandom), sq, 2'($urandom), si};
        cfg_tvalid = cfg;
        cfg_tdata  = {16'($urandom), cd[15:0]};
        resync     = rs;
        m_tready   = rdy;
        @(posedge clk);
        model_update(v, si, sq, cfg, cd, rs, rdy);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, '0, '0, 0, '0, 0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 96'd0);
        chk("rst_tuser", m_tuser, 16'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_tready", ddc_tready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [29:0] p1000;
    logic [29:0] m1000;
    logic [29:0] imax;
    logic [29:0] imin;
    longint      big;
    longint      neg;

    initial begin
        p1000 = 30'd1000;
        m1000 = 30'(-1000);
        imax  = 30'h1FFF_FFFF;
        imin  = 30'h2000_0000;

        do_reset();

        // samples before any cfg write produce nothing
        for (int k = 0; k < 6; k++) step(1, p1000, m1000, 0, '0, 0, 1);

        // cfg + resync + sample: sample discarded, N=4 latched
        step(1, p1000, m1000, 1, 32'd4, 1, 1);
        for (int k = 0; k < 4; k++) step(1, p1000, m1000, 0, '0, 0, 1);
        chk("n4_first_i", m_tdata[47:0], 48'd4000);
        chk("n4_first_u", m_tuser, 16'd0);
        for (int k = 0; k < 12; k++) step(1, p1000, m1000, 0, '0, 0, 1);
        idle(3, 1);

        // N=1 with full-scale input
        step(0, '0, '0, 1, 32'd1, 0, 1);
        step(1, imax, imin, 0, '0, 0, 1);
        neg = -536870912;
        chk("n1_max_i", m_tdata[47:0], 48'd536870911);
        chk("n1_min_q", m_tdata[95:48], neg[47:0]);
        for (int k = 0; k < 4; k++) step(1, imax, imin, 0, '0, 0, 1);
        idle(2, 1);

        // gapped valid, N=3
        step(0, '0, '0, 1, 32'd3, 0, 1);
        for (int k = 0; k < 18; k++)
            step(k % 3 == 0, 30'($urandom), 30'($urandom), 0, '0, 0, 1);
        idle(2, 1);

        // overflow: N=1, stalled output
        step(0, '0, '0, 1, 32'd1, 0, 1);
        for (int k = 0; k < 10; k++)
            step(1, 30'(k + 1), 30'(k), 0, '0, 0, 0);
        chk("ovf_set", overflow, 1'b1);
        idle(4, 1);
        step(1, p1000, p1000, 0, '0, 0, 1);
        chk("ovf_gap_tuser", m_tuser, 16'd10);
        idle(2, 1);
        step(0, '0, '0, 1, 32'd1, 0, 1);
        chk("ovf_cleared", overflow, 1'b0);

        // resync mid-window and on the Nth sample
        step(0, '0, '0, 1, 32'd8, 0, 1);
        for (int k = 0; k < 5; k++) step(1, 30'(k), 30'(k), 0, '0, 0, 1);
        step(1, p1000, p1000, 0, '0, 1, 1);
        for (int k = 0; k < 8; k++)
            step(1, 30'($urandom), 30'($urandom), 0, '0, 0, 1);
        idle(2, 1);
        for (int k = 0; k < 7; k++) step(1, p1000, p1000, 0, '0, 0, 1);
        step(1, p1000, p1000, 0, '0, 1, 1);
        chk("resync_nth_nodump", m_tvalid, 1'b0);
        idle(2, 1);

        // randomized traffic
        step(0, '0, '0, 1, 32'($urandom_range(1, 6)), 0, 1);
        for (int k = 0; k < 600; k++) begin
            step($urandom % 4 != 0, 30'($urandom), 30'($urandom),
                 $urandom % 150 == 0, 32'($urandom_range(0, 6)),
                 $urandom % 50 == 0, $urandom % 3 != 0);
        end
        idle(6, 1);

        // largest N with max input: no wrap
        step(0, '0, '0, 1, 32'd65535, 0, 1);
        for (int k = 0; k < 65535; k++) step(1, imax, imax, 0, '0, 0, 1);
        big = longint'(536870911) * 65535;
        chk("nmax_i", m_tdata[47:0], big[47:0]);
        idle(2, 1);

        // reset mid-window with FIFO occupied and valid high
        step(0, '0, '0, 1, 32'd1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, p1000, p1000, 0, '0, 0, 0);
        step(0, '0, '0, 1, 32'd4, 0, 0);
        step(1, p1000, p1000, 0, '0, 0, 0);
        ddc_tvalid = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) step(1, p1000, p1000, 0, '0, 0, 1);
        chk("post_rst_uncfg", m_tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
